// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus UART: register offsets, STATUS bit
// positions, CONTROL bit positions and the TX/RX state encodings.
package bus_uart_pkg;

  // Word index within the 16-byte window (address[3:2])
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_RX_VALID   = 3;
  localparam int ST_RX_OVERRUN = 4;

  // CONTROL write bit positions
  localparam int CTRL_CLR_VALID = 0;
  localparam int CTRL_CLR_ERR   = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/bus_uart_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// A push while full is dropped even if a pop happens on the same edge,
// because full is judged on the pre-edge count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset since count guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap as DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART on the CPU data bus with a TX FIFO and a
// one-byte RX holding register. Reads are combinational.
//
// TX state | meaning
// ---------+-------------------------------------------------------
// TX_IDLE  | line high; pops FIFO head into shifter when not empty
// TX_START | start bit (0) for CLK_DIV cycles
// TX_DATA  | 8 data bits LSB-first, CLK_DIV cycles each
// TX_STOP  | stop bit (1) for CLK_DIV cycles
//
// RX state | meaning
// ---------+-------------------------------------------------------
// RX_IDLE  | waiting for a synchronised 1->0 edge
// RX_START | half-bit wait, then confirm line still low
// RX_DATA  | sample 8 bits LSB-first, one per CLK_DIV cycles
// RX_STOP  | sample stop bit; commit byte or flag an error
module bus_uart
  import bus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'hF000_0000,
  parameter int          CLK_DIV       = 434,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] busDataIn,
  input  logic        busWriteEnable,
  output logic [31:0] busDataOut,
  output logic        selected,
  output logic        uartTx,
  input  logic        uartRx
);

  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);

  logic [1:0]  reg_idx;
  logic        wr_en;
  logic        push;
  logic        ctrl_wr;
  logic        clr_valid;
  logic        clr_err;
  logic        unused_bits;

  logic        fifo_pop;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_busy;

  logic [1:0]  rx_sync;
  logic        rx_s;
  logic        rx_prev;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;

  logic [31:0] status_word;

  assign selected    = (address[31:4] == BASE_ADDR[31:4]);
  assign reg_idx     = address[3:2];
  assign wr_en       = selected & busWriteEnable;
  assign push        = wr_en && (reg_idx == REG_TXDATA);
  assign ctrl_wr     = wr_en && (reg_idx == REG_CONTROL);
  assign clr_valid   = ctrl_wr & busDataIn[CTRL_CLR_VALID];
  assign clr_err     = ctrl_wr & busDataIn[CTRL_CLR_ERR];
  assign unused_bits = ^{busDataIn[31:8], address[1:0]};

  assign tx_busy  = (tx_state != TX_IDLE);
  assign fifo_pop = (tx_state == TX_IDLE) & ~fifo_empty;
  assign rx_s     = rx_sync[1];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(busDataIn[7:0]),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // TX FSM; uartTx is registered from the current state, so the line
  // trails the state by one cycle (start bit appears 2 cycles after push)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      uartTx   <= 1'b1;
    end else begin
      case (tx_state)
        TX_START: uartTx <= 1'b0;
        TX_DATA:  uartTx <= tx_shift[0];
        default:  uartTx <= 1'b1;
      endcase
      case (tx_state)
        TX_IDLE: begin
          if (!fifo_empty) begin
            tx_shift <= fifo_head;
            tx_cnt   <= DIV_M1;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= DIV_M1;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt   <= DIV_M1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
            else                tx_bit   <= tx_bit + 3'd1;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) tx_state <= TX_IDLE;
          else              tx_cnt   <= tx_cnt - 16'd1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uartRx};
      rx_prev <= rx_s;
    end
  end

  // RX FSM and holding register; a landing byte overrides a same-edge clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_shift   <= '0;
      rx_bit     <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (clr_valid) rx_valid <= 1'b0;
      if (clr_err) begin
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_cnt   <= HALF_M1;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == '0) begin
            if (!rx_s) begin
              rx_cnt   <= DIV_M1;
              rx_bit   <= '0;
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= DIV_M1;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            if (rx_s) begin
              if (rx_valid && !clr_valid) begin
                rx_overrun <= 1'b1;
              end else begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // STATUS assembly
  always_comb begin
    status_word                = '0;
    status_word[ST_TX_FULL]    = fifo_full;
    status_word[ST_TX_EMPTY]   = fifo_empty;
    status_word[ST_TX_BUSY]    = tx_busy;
    status_word[ST_RX_VALID]   = rx_valid;
    status_word[ST_RX_OVERRUN] = rx_overrun;
  end

  // Zero-wait read mux; drives 0 whenever the window is not addressed
  always_comb begin
    busDataOut = '0;
    if (selected) begin
      case (reg_idx)
        REG_RXDATA:  busDataOut = {23'b0, rx_valid, rx_byte};
        REG_STATUS:  busDataOut = status_word;
        REG_CONTROL: busDataOut = {31'b0, frame_err};
        default:     busDataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_uart.sv
// Directed plus randomised bench for bus_uart with CLK_DIV=4.
module tb_bus_uart;

  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] busDataIn = '0;
  logic        busWriteEnable = 1'b0;
  logic [31:0] busDataOut;
  logic        selected;
  logic        uartTx;
  logic        uartRx = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic last_sel;

  // RX reference model state
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;
  logic [7:0] m_byte = 8'h00;

  // frames decoded from uartTx
  logic [7:0] mon_byte[$];
  logic       mon_stop[$];
  int         mon_start[$];

  bus_uart #(
    .BASE_ADDR(BASE),
    .CLK_DIV(DIV),
    .TX_FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .busDataIn(busDataIn),
    .busWriteEnable(busWriteEnable),
    .busDataOut(busDataOut),
    .selected(selected),
    .uartTx(uartTx),
    .uartRx(uartRx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // call at a negedge; write commits on the following posedge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a; busDataIn = d; busWriteEnable = 1'b1;
    @(negedge clk);
    busWriteEnable = 1'b0; address = '0; busDataIn = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a; busWriteEnable = 1'b0;
    #1;
    d = busDataOut;
    last_sel = selected;
    address = '0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uartRx = f[i];
      repeat (DIV) @(negedge clk);
    end
    uartRx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_frame(b, stop);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      else begin m_byte = b; m_valid = 1'b1; end
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic ctrl(input logic [1:0] v);
    wr(BASE + 32'd12, {30'b0, v});
    if (v[0]) m_valid = 1'b0;
    if (v[1]) begin m_ovr = 1'b0; m_ferr = 1'b0; end
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] d;
    rd(BASE + 32'd4, d);
    check({tag, "_rxdata"}, d, {23'b0, m_valid, m_byte});
    rd(BASE + 32'd8, d);
    check({tag, "_status"}, d, {27'b0, m_ovr, m_valid, 3'b010});
    rd(BASE + 32'd12, d);
    check({tag, "_control"}, d, {31'b0, m_ferr});
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t;
    t = 0;
    while (mon_byte.size() < n && t < n * (10 * DIV + 2) + 60) begin
      @(negedge clk);
      t++;
    end
    check(tag, mon_byte.size(), n);
  endtask

  task automatic clear_mon();
    mon_byte.delete(); mon_stop.delete(); mon_start.delete();
  endtask

  // line decoder: mid-bit sampling after a detected start bit
  initial begin : tx_mon
    logic [7:0] b;
    logic s;
    int t0;
    forever begin
      @(negedge clk);
      if (!reset && uartTx === 1'b0) begin
        t0 = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clk);
          b[k] = uartTx;
        end
        repeat (DIV) @(negedge clk);
        s = uartTx;
        mon_byte.push_back(b);
        mon_stop.push_back(s);
        mon_start.push_back(t0);
      end
    end
  end

  initial begin : stim
    logic [31:0] d;
    logic [7:0]  v;
    logic [7:0]  exp_q[$];
    logic [9:0]  f;
    int lat, bad, n, gap;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    rd(BASE + 32'd8, d);  check("rst_status", d, 32'h2);
    rd(BASE + 32'd4, d);  check("rst_rxdata", d, 32'h0);
    rd(BASE + 32'd12, d); check("rst_control", d, 32'h0);
    rd(BASE, d);          check("rst_txdata_read", d, 32'h0);
    check("sel_base", last_sel, 1'b1);
    check("rst_uarttx", uartTx, 1'b1);

    // single byte 0xA5, cycle-exact line check
    @(negedge clk);
    wr(BASE, 32'hA5);
    lat = 0;
    while (uartTx !== 1'b0 && lat < 10) begin @(negedge clk); lat++; end
    check("tx_latency", lat, 2);
    f = {1'b1, 8'hA5, 1'b0};
    bad = 0;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (uartTx !== f[k / DIV]) bad++;
      @(negedge clk);
    end
    check("tx_a5_waveform", bad, 0);
    repeat (4) @(negedge clk);
    rd(BASE + 32'd8, d); check("tx_a5_status_idle", d, 32'h2);
    wait_frames(1, "tx_a5_frames");
    if (mon_byte.size() > 0) check("tx_a5_byte", mon_byte[0], 8'hA5);
    clear_mon();

    // FIFO full: 9 back-to-back pushes, 10th dropped
    exp_q.delete();
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back(v);
      address = BASE; busDataIn = {24'h0, v}; busWriteEnable = 1'b1;
      @(negedge clk);
    end
    busWriteEnable = 1'b0; address = '0; busDataIn = '0;
    rd(BASE + 32'd8, d); check("fifo_full_status", d, 32'h5);
    @(negedge clk);
    wr(BASE, 32'h5A);
    rd(BASE + 32'd8, d); check("fifo_drop_status", d, 32'h5);
    wait_frames(9, "fifo_frame_count");
    for (int i = 0; i < 9; i++) begin
      if (i < mon_byte.size()) begin
        check($sformatf("fifo_byte%0d", i), mon_byte[i], exp_q[i]);
        check($sformatf("fifo_stop%0d", i), mon_stop[i], 1'b1);
      end
      if (i > 0 && i < mon_start.size()) begin
        gap = mon_start[i] - mon_start[i-1];
        check($sformatf("fifo_gap%0d", i), (gap >= 10 * DIV && gap <= 10 * DIV + 1), 1'b1);
      end
    end
    repeat (60) @(negedge clk);
    check("fifo_10th_dropped", mon_byte.size(), 9);
    rd(BASE + 32'd8, d); check("fifo_drained_status", d, 32'h2);
    clear_mon();

    // asynchronous reset in the middle of a frame
    @(negedge clk);
    wr(BASE, 32'h00);
    wr(BASE, 32'hFF);
    repeat (12) @(negedge clk);
    check("mid_frame_low", uartTx, 1'b0);
    #2 reset = 1'b1;
    #1 check("reset_async_tx", uartTx, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    rd(BASE + 32'd8, d); check("reset_status", d, 32'h2);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (uartTx !== 1'b1) bad++;
      @(negedge clk);
    end
    check("reset_no_resume", bad, 0);
    clear_mon();

    // RX single byte and acknowledge
    send_rx(8'h3C, 1'b1);
    rd(BASE + 32'd4, d); check("rx_3c_const", d, 32'h13C);
    check_rx("rx_3c");
    ctrl(2'b01);
    rd(BASE + 32'd4, d); check("rx_ack_const", d, 32'h03C);
    check_rx("rx_ack");

    // overrun: second byte without ack keeps the first
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    rd(BASE + 32'd4, d); check("rx_ovr_rxdata", d, 32'h111);
    rd(BASE + 32'd8, d); check("rx_ovr_bit4", d[4], 1'b1);
    check_rx("rx_ovr");

    // framing error, then clear with CONTROL bit1
    send_rx(8'h33, 1'b0);
    rd(BASE + 32'd12, d); check("rx_ferr_const", d, 32'h1);
    check_rx("rx_ferr");
    ctrl(2'b10);
    rd(BASE + 32'd12, d); check("rx_ferr_clr_const", d, 32'h0);
    check_rx("rx_ferr_clr");
    ctrl(2'b01);

    // one-cycle glitch on uartRx must not start a frame
    uartRx = 1'b0;
    @(negedge clk);
    uartRx = 1'b1;
    repeat (12) @(negedge clk);
    check_rx("rx_glitch");

    // randomised TX bursts against a byte queue
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      exp_q.delete();
      n = $urandom_range(1, 8);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom_range(0, 255));
        exp_q.push_back(v);
        address = BASE; busDataIn = {24'h0, v}; busWriteEnable = 1'b1;
        @(negedge clk);
      end
      busWriteEnable = 1'b0; address = '0; busDataIn = '0;
      wait_frames(n, $sformatf("rand_tx%0d_count", r));
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (i >= mon_byte.size() || mon_byte[i] !== exp_q[i] || mon_stop[i] !== 1'b1) bad++;
      end
      check($sformatf("rand_tx%0d_bytes", r), bad, 0);
      repeat (4) @(negedge clk);
    end
    clear_mon();

    // randomised RX frames and CONTROL writes against the model
    for (int r = 0; r < 6; r++) begin
      v = 8'($urandom_range(0, 255));
      send_rx(v, ($urandom_range(0, 3) != 0));
      check_rx($sformatf("rand_rx%0d", r));
      if ($urandom_range(0, 1) == 1) begin
        ctrl(2'($urandom_range(0, 3)));
        check_rx($sformatf("rand_rx%0d_ctl", r));
      end
    end

    // address decode: outside the window nothing responds or changes
    ctrl(2'b11);
    send_rx(8'h5E, 1'b1);
    clear_mon();
    rd(BASE + 32'd16, d);
    check("dec_b16_data", d, 32'h0);
    check("dec_b16_sel", last_sel, 1'b0);
    rd(32'h0000_0000, d);
    check("dec_zero_data", d, 32'h0);
    check("dec_zero_sel", last_sel, 1'b0);
    @(negedge clk);
    wr(BASE + 32'd16, 32'h77);
    wr(BASE + 32'd28, 32'h3);
    wr(32'h0000_0000, 32'h77);
    wr(32'h0000_000C, 32'h3);
    wr(BASE + 32'd4, 32'hFFFF_FFFF);
    wr(BASE + 32'd8, 32'hFFFF_FFFF);
    check_rx("dec_nochange");
    repeat (60) @(negedge clk);
    check("dec_no_tx", mon_byte.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
